// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

  // log2 of the instruction size; INST_BYTES is restricted to 2 or 4.
  function automatic int align_bits(input int inst_bytes);
    return (inst_bytes == 4) ? 2 : 1;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority next-pc selector with redirect alignment check.
// Order: trap > branch/jump > stall > fetch handshake advance > hold.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_BYTES = 4
) (
  input  logic            run_i,
  input  logic            stall_i,
  input  logic            npc_sel_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            fetch_valid_i,
  input  logic            fetch_ready_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            load_o,
  output logic            misalign_o
);

  localparam int              ALIGN_BITS = align_bits(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << ALIGN_BITS) - 1);

  logic            redir;
  logic [XLEN-1:0] target;
  logic            bad;

  assign redir  = trap_i | npc_sel_i;
  assign target = trap_i ? trap_vec_i : alu_res_i;
  assign bad    = (target & ALIGN_MASK) != '0;

  // Pick the next pc; a misaligned redirect is rejected and pc holds.
  always_comb begin
    next_pc_o  = pc4_i;
    load_o     = 1'b0;
    misalign_o = 1'b0;
    if (run_i) begin
      if (redir) begin
        next_pc_o  = target;
        load_o     = ~bad;
        misalign_o = bad;
      end else if (!stall_i && fetch_valid_i && fetch_ready_i) begin
        load_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot sequencing, pc register and fetch handshake.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter int              INST_BYTES   = 4
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            npc_sel,
  input  logic [XLEN-1:0] alu_res,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            misalign_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, next_pc;
  logic            fetch_valid_q, fetch_valid_d;
  logic            misalign_q, misalign_d;
  logic            load, sel_misalign, run;

  assign run = (state_q == RUN);
  assign pc4 = pc_q + XLEN'(INST_BYTES);

  pc_next_sel #(.XLEN(XLEN), .INST_BYTES(INST_BYTES)) u_sel (
    .run_i        (run),
    .stall_i      (stall_i),
    .npc_sel_i    (npc_sel),
    .alu_res_i    (alu_res),
    .trap_i       (trap_i),
    .trap_vec_i   (trap_vec),
    .fetch_valid_i(fetch_valid_q),
    .fetch_ready_i(fetch_ready),
    .pc4_i        (pc4),
    .next_pc_o    (next_pc),
    .load_o       (load),
    .misalign_o   (sel_misalign)
  );

  // Next state and registered outputs; a rejected redirect drops valid for a cycle.
  always_comb begin
    state_d       = RUN;
    fetch_valid_d = ~sel_misalign;
    misalign_d    = sel_misalign;
  end

  // State, pc and handshake registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
      if (load) pc_q <= next_pc;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign misalign_o  = misalign_q;

endmodule
